// File: rtl/roberts_stream_engine.sv
// Streaming Roberts-cross edge engine: raster pixels in, one gradient magnitude out
// per pixel with r>=1 and c>=1. The previous row is kept in an internal line buffer.
module roberts_stream_engine #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned MAX_W = 1024,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic [CNT_W-1:0] height_i,
  input  logic [1:0]       mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [PIX_W-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [PIX_W-1:0] out_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] width_q, height_q, row_q, col_q;
  logic [1:0]       mode_q;
  logic [PIX_W-1:0] lb [MAX_W];
  logic [PIX_W-1:0] prev_up_q, prev_cur_q, up;
  logic             out_valid_q, err_q;
  logic [PIX_W-1:0] out_data_q;

  logic             geom_ok, start_ok, in_fire, out_fire, last_px, qualify, col_last;
  logic [PIX_W:0]   gx, gy, sum;
  logic [PIX_W-1:0] abs_gx, abs_gy, grad;

  assign geom_ok  = (width_i >= CNT_W'(2)) && (width_i <= CNT_W'(MAX_W)) &&
                    (height_i >= CNT_W'(2));
  assign start_ok = (state_q == IDLE) && start_i && geom_ok;

  assign in_ready_o = (state_q == RUN) && (!out_valid_q || out_ready_i);
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_fire   = out_valid_q && out_ready_i;

  assign col_last = (col_q == width_q - CNT_W'(1));
  assign last_px  = (row_q == height_q - CNT_W'(1)) && col_last;
  assign qualify  = (row_q != '0) && (col_q != '0);

  // Row 0 never reads lb, so stale contents from an abandoned frame are harmless.
  assign up = lb[col_q[AW-1:0]];

  // Gradients are PIX_W+1 two's complement; the magnitude always fits in PIX_W bits.
  assign gx     = {1'b0, prev_up_q} - {1'b0, in_data_i};
  assign gy     = {1'b0, up} - {1'b0, prev_cur_q};
  assign abs_gx = gx[PIX_W] ? PIX_W'(-gx) : gx[PIX_W-1:0];
  assign abs_gy = gy[PIX_W] ? PIX_W'(-gy) : gy[PIX_W-1:0];
  assign sum    = {1'b0, abs_gx} + {1'b0, abs_gy};

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    grad = '0;
    unique case (mode_q)
      2'd0:    grad = sum[PIX_W] ? '1 : sum[PIX_W-1:0];
      2'd1:    grad = (abs_gx > abs_gy) ? abs_gx : abs_gy;
      2'd2:    grad = abs_gx;
      default: grad = abs_gy;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: combinational logic uses blocking '=', clocked state uses non-blocking '<='.
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start_ok) state_d = RUN;
        RUN:     if (in_fire && last_px) state_d = DRAIN;
        DRAIN:   if (!out_valid_q || out_ready_i) state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      width_q     <= '0;
      height_q    <= '0;
      mode_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      prev_up_q   <= '0;
      prev_cur_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else if (clear_i) begin
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE) && start_i && !geom_ok;
      if (start_ok) begin
        width_q  <= width_i;
        height_q <= height_i;
        mode_q   <= mode_i;
        row_q    <= '0;
        col_q    <= '0;
      end
      if (in_fire) begin
        prev_up_q  <= up;
        prev_cur_q <= in_data_i;
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + CNT_W'(1);
        end else begin
          col_q <= col_q + CNT_W'(1);
        end
      end
      // A new result may replace the one being accepted on the same edge.
      if (in_fire && qualify) begin
        out_valid_q <= 1'b1;
        out_data_q  <= grad;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: the line buffer is deliberately not reset; it is a plain RAM and is always
  // written before it is read within a frame.
  always_ff @(posedge clk_i) begin
    if (in_fire) lb[col_q[AW-1:0]] <= in_data_i;
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_roberts_stream_engine.sv
// Directed bench for roberts_stream_engine: table of 2x2 frames, larger frames with
// backpressure, illegal starts and a mid-frame clear, all checked against a 2-D model.
module tb_roberts_stream_engine;

  localparam int PIX_W = 8;
  localparam int MAX_W = 1024;
  localparam int CNT_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             clear_i = 1'b0;
  logic             start_i = 1'b0;
  logic [CNT_W-1:0] width_i = '0;
  logic [CNT_W-1:0] height_i = '0;
  logic [1:0]       mode_i = '0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [PIX_W-1:0] in_data_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b1;
  logic [PIX_W-1:0] out_data_o;
  logic             busy_o, done_o, err_o;

  roberts_stream_engine #(.PIX_W(PIX_W), .MAX_W(MAX_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .width_i(width_i), .height_i(height_i), .mode_i(mode_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int         total = 0;
  int         bad = 0;
  int         pix[64];
  logic [7:0] last_out;

  typedef struct {
    int p0, p1, p2, p3;
    int mode;
    int exp;
  } vec_t;

  typedef struct {
    int w, h;
  } geom_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int golden(int w, int r, int c, int m);
    int p, pu, up, pc, ax, ay;
    p  = pix[r * w + c];
    pu = pix[(r - 1) * w + c - 1];
    up = pix[(r - 1) * w + c];
    pc = pix[r * w + c - 1];
    ax = (pu > p) ? pu - p : p - pu;
    ay = (up > pc) ? up - pc : pc - up;
    case (m)
      0:       return (ax + ay > 255) ? 255 : ax + ay;
      1:       return (ax > ay) ? ax : ay;
      2:       return ax;
      default: return ay;
    endcase
  endfunction

  // Runs one frame from the pixels in pix[]. stall_pct is the chance per cycle that
  // out_ready_i is low; abort_beat >= 0 issues clear_i once that many beats were accepted.
  task automatic run_frame(input string tag, input int w, input int h, input int m,
                           input int stall_pct, input int abort_beat);
    int         exp_q[$];
    int         sent = 0, got = 0, cycles = 0, dones = 0, stall_err = 0, bubbles = 0;
    bit         stalled = 0, finished = 0, aborted = 0;
    logic [7:0] held = '0;
    for (int r = 1; r < h; r++)
      for (int c = 1; c < w; c++)
        exp_q.push_back(golden(w, r, c, m));

    @(negedge clk_i);
    start_i = 1'b1; width_i = CNT_W'(w); height_i = CNT_W'(h); mode_i = 2'(m);
    @(negedge clk_i);
    start_i = 1'b0; width_i = CNT_W'(1); height_i = CNT_W'(1); mode_i = 2'(m + 1);

    while (!finished && cycles < 3000) begin
      if (abort_beat >= 0 && sent == abort_beat) begin
        aborted = 1;
        break;
      end
      out_ready_i = ($urandom_range(99) >= stall_pct);
      in_valid_i  = (sent < w * h);
      in_data_i   = in_valid_i ? 8'(pix[sent]) : 8'($urandom_range(255));
      #1;
      if (stalled && (!out_valid_o || out_data_o !== held)) stall_err++;
      if (done_o) begin
        dones++;
        finished = 1;
        check($sformatf("%s done_after_last_out", tag), got, exp_q.size());
      end
      if (in_valid_i && !in_ready_o) bubbles++;
      if (in_valid_i && in_ready_o) sent++;
      if (out_valid_o && out_ready_i) begin
        if (got < exp_q.size())
          check($sformatf("%s out[%0d]", tag, got), out_data_o, exp_q[got]);
        else
          check($sformatf("%s extra_out", tag), got, exp_q.size() - 1);
        last_out = out_data_o;
        got++;
      end
      stalled = out_valid_o && !out_ready_i;
      held    = out_data_o;
      @(negedge clk_i);
      cycles++;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    check($sformatf("%s data_stable_while_stalled", tag), stall_err, 0);

    if (aborted) begin
      int late_done = 0;
      clear_i    = 1'b1;
      in_valid_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
      #1;
      check($sformatf("%s clear busy", tag), busy_o, 0);
      check($sformatf("%s clear out_valid", tag), out_valid_o, 0);
      check($sformatf("%s clear in_ready", tag), in_ready_o, 0);
      for (int i = 0; i < 6; i++) begin
        if (done_o || err_o) late_done++;
        @(negedge clk_i);
        #1;
      end
      in_valid_i = 1'b0;
      check($sformatf("%s clear no done/err pulse", tag), late_done, 0);
    end else begin
      check($sformatf("%s frame_finished", tag), finished, 1);
      check($sformatf("%s outputs", tag), got, exp_q.size());
      check($sformatf("%s done_pulses", tag), dones, 1);
      if (stall_pct == 0) check($sformatf("%s input_bubbles", tag), bubbles, 0);
      @(negedge clk_i);
      #1;
      check($sformatf("%s busy_after", tag), busy_o, 0);
      check($sformatf("%s done_after", tag), done_o, 0);
    end
  endtask

  vec_t  vecs[14];
  geom_t bad_geo[3];

  initial begin
    vecs[0]  = '{255, 0, 0, 255, 0, 0};
    vecs[1]  = '{255, 0, 0, 255, 2, 0};
    vecs[2]  = '{255, 0, 0, 0, 0, 255};
    vecs[3]  = '{0, 255, 255, 0, 0, 0};
    vecs[4]  = '{0, 255, 255, 0, 3, 0};
    vecs[5]  = '{255, 255, 0, 0, 0, 255};
    vecs[6]  = '{255, 255, 0, 0, 1, 255};
    vecs[7]  = '{10, 50, 30, 0, 0, 30};
    vecs[8]  = '{10, 50, 30, 0, 1, 20};
    vecs[9]  = '{10, 50, 30, 0, 2, 10};
    vecs[10] = '{10, 50, 30, 0, 3, 20};
    vecs[11] = '{0, 200, 100, 250, 0, 255};
    vecs[12] = '{0, 200, 100, 250, 1, 250};
    vecs[13] = '{0, 200, 100, 250, 3, 100};
    bad_geo[0] = '{1, 4};
    bad_geo[1] = '{MAX_W + 1, 4};
    bad_geo[2] = '{4, 1};

    #1;
    check("reset in_ready", in_ready_o, 0);
    check("reset out_valid", out_valid_o, 0);
    check("reset out_data", out_data_o, 0);
    check("reset busy", busy_o, 0);
    check("reset done", done_o, 0);
    check("reset err", err_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 12; i++) pix[i] = i;
    run_frame("ramp4x3", 4, 3, 0, 0, -1);
    check("ramp4x3 value", last_out, 8);

    for (int i = 0; i < 14; i++) begin
      pix[0] = vecs[i].p0; pix[1] = vecs[i].p1; pix[2] = vecs[i].p2; pix[3] = vecs[i].p3;
      run_frame($sformatf("vec%0d", i), 2, 2, vecs[i].mode, 0, -1);
      check($sformatf("vec%0d table", i), last_out, vecs[i].exp);
    end

    for (int i = 0; i < 64; i++) pix[i] = $urandom_range(255);
    run_frame("bp8x8", 8, 8, 0, 30, -1);

    for (int i = 0; i < 15; i++) pix[i] = $urandom_range(255);
    run_frame("bp5x3m1", 5, 3, 1, 50, -1);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      start_i = 1'b1; in_valid_i = 1'b1;
      width_i = CNT_W'(bad_geo[i].w); height_i = CNT_W'(bad_geo[i].h);
      @(negedge clk_i);
      start_i = 1'b0;
      #1;
      check($sformatf("illegal%0d err", i), err_o, 1);
      check($sformatf("illegal%0d busy", i), busy_o, 0);
      check($sformatf("illegal%0d in_ready", i), in_ready_o, 0);
      @(negedge clk_i);
      #1;
      check($sformatf("illegal%0d err_one_cycle", i), err_o, 0);
      check($sformatf("illegal%0d busy_after", i), busy_o, 0);
      in_valid_i = 1'b0;
    end

    for (int i = 0; i < 16; i++) pix[i] = $urandom_range(255);
    run_frame("abort4x4", 4, 4, 0, 0, 10);
    for (int i = 0; i < 16; i++) pix[i] = $urandom_range(255);
    run_frame("after_clear4x4", 4, 4, 2, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
